xif_coproc_alu: RTL and testbench

XIF_COPROC_ALU -- requirements
Module: xif_coproc_alu

---
 rtl/xif_coproc_alu.sv | 201 ++++++++++++++++++++
 tb/tb_xif_coproc_alu.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xif_coproc_alu.sv
// xif_coproc_alu: small XIF coprocessor executing custom-0 ADD/XOR, with an
// in-order result FIFO whose entries wait for commit or kill from the CPU.
// Optional feature macro: XIF_COPROC_SUB_EN adds SUB on funct3 010.
//
// Handshake semantics (issue and result channels): a transfer happens on a
// rising edge where valid && ready are both 1. The issue side never waits for
// valid before raising ready. Once result_valid is 1 it stays 1 and result_*
// stay stable until the transfer completes.
module xif_coproc_alu #(
  parameter int DEPTH      = 4,
  parameter int X_ID_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic [31:0]           issue_instr,
  input  logic [X_ID_WIDTH-1:0] issue_id,
  input  logic [63:0]           issue_rs,
  input  logic [1:0]            issue_rs_valid,
  output logic                  issue_accept,
  output logic                  issue_writeback,
  output logic                  issue_dualwrite,
  output logic                  issue_dualread,
  output logic                  issue_loadstore,
  output logic                  issue_exc,
  input  logic                  commit_valid,
  input  logic [X_ID_WIDTH-1:0] commit_id,
  input  logic                  commit_kill,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [X_ID_WIDTH-1:0] result_id,
  output logic [31:0]           result_data,
  output logic [4:0]            result_rd,
  output logic                  result_we,
  output logic                  result_exc,
  output logic [5:0]            result_exccode
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;

  typedef enum logic [1:0] {
    ST_WAIT      = 2'd0,
    ST_COMMITTED = 2'd1,
    ST_KILLED    = 2'd2
  } ent_state_e;

  typedef struct packed {
    logic                  valid;
    ent_state_e            state;
    logic [X_ID_WIDTH-1:0] id;
    logic [4:0]            rd;
    logic [31:0]           data;
    logic                  we;
  } entry_t;

  // Head-of-queue view: the per-entry FSM state that decides the result side.
  typedef struct packed {
    logic       valid;
    ent_state_e state;
  } head_dbg_t;

  entry_t        entries_q [DEPTH];
  entry_t        entries_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [31:0] rs1, rs2;
  logic [4:0]  issue_rd;
  logic        dec_accept;
  logic [31:0] alu_result;
  logic        push, pop, drop_killed;
  entry_t      head_e;
  head_dbg_t   head_dbg;
  logic        unused_instr_bits;

  assign rs1               = issue_rs[31:0];
  assign rs2               = issue_rs[63:32];
  assign issue_rd          = issue_instr[11:7];
  assign unused_instr_bits = ^issue_instr[24:15];

  // Decode the offered instruction and compute its result in the same cycle.
  always_comb begin
    dec_accept = 1'b0;
    alu_result = '0;
    if (issue_instr[6:0] == OPC_CUSTOM0 && issue_instr[31:25] == 7'd0) begin
      case (issue_instr[14:12])
        3'b000: begin
          dec_accept = 1'b1;
          alu_result = rs1 + rs2;
        end
        3'b001: begin
          dec_accept = 1'b1;
          alu_result = rs1 ^ rs2;
        end
`ifdef XIF_COPROC_SUB_EN
        3'b010: begin
          dec_accept = 1'b1;
          alu_result = rs1 - rs2;
        end
`endif
        default: begin
          dec_accept = 1'b0;
          alu_result = '0;
        end
      endcase
    end
  end

  // Ready depends only on registered occupancy, so a pop never frees a slot
  // for an issue in the same cycle.
  assign issue_ready     = !rst && (count_q < DEPTH_C) && (issue_rs_valid == 2'b11);
  assign issue_accept    = dec_accept;
  assign issue_writeback = dec_accept && (issue_rd != 5'd0);
  assign issue_dualwrite = 1'b0;
  assign issue_dualread  = 1'b0;
  assign issue_loadstore = 1'b0;
  assign issue_exc       = 1'b0;

  assign push = issue_valid && issue_ready && dec_accept;

  // Expose the head entry and its state for the result side.
  always_comb begin
    head_e         = entries_q[rd_ptr_q];
    head_dbg.valid = head_e.valid;
    head_dbg.state = head_e.state;
  end

  assign result_valid = !rst && head_dbg.valid && (head_dbg.state == ST_COMMITTED);
  assign drop_killed  = !rst && head_dbg.valid && (head_dbg.state == ST_KILLED);
  assign pop          = (result_valid && result_ready) || drop_killed;

  assign result_id      = result_valid ? head_e.id   : '0;
  assign result_data    = result_valid ? head_e.data : '0;
  assign result_rd      = result_valid ? head_e.rd   : '0;
  assign result_we      = result_valid && head_e.we;
  assign result_exc     = 1'b0;
  assign result_exccode = '0;

  // Next state: commit/kill matching waiting entries, pop the head, push the tail.
  always_comb begin
    entries_d = entries_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (commit_valid) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (entries_q[i].valid && entries_q[i].state == ST_WAIT &&
            entries_q[i].id == commit_id) begin
          entries_d[i].state = commit_kill ? ST_KILLED : ST_COMMITTED;
        end
      end
    end
    if (pop) begin
      entries_d[rd_ptr_q].valid = 1'b0;
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push) begin
      entries_d[wr_ptr_q].valid = 1'b1;
      entries_d[wr_ptr_q].id    = issue_id;
      entries_d[wr_ptr_q].rd    = issue_rd;
      entries_d[wr_ptr_q].data  = alu_result;
      entries_d[wr_ptr_q].we    = issue_writeback;
      // A commit aimed at the instruction being issued this cycle lands here.
      if (commit_valid && commit_id == issue_id) begin
        entries_d[wr_ptr_q].state = commit_kill ? ST_KILLED : ST_COMMITTED;
      end else begin
        entries_d[wr_ptr_q].state = ST_WAIT;
      end
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers with synchronous reset that drops all in-flight entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= entries_d[i];
      end
    end
  end

endmodule

// File: tb/tb_xif_coproc_alu.sv
// tb_xif_coproc_alu: vector table, directed multi-cycle sequences and a
// randomized run against a queue-based reference model.
module tb_xif_coproc_alu;
  localparam int DEPTH = 4;
  localparam int XW    = 4;
  localparam logic [6:0] OPC = 7'b0001011;
`ifdef XIF_COPROC_SUB_EN
  localparam logic SUB_EN = 1'b1;
`else
  localparam logic SUB_EN = 1'b0;
`endif

  logic          clk, rst;
  logic          issue_valid, issue_ready;
  logic [31:0]   issue_instr;
  logic [XW-1:0] issue_id;
  logic [63:0]   issue_rs;
  logic [1:0]    issue_rs_valid;
  logic          issue_accept, issue_writeback, issue_dualwrite;
  logic          issue_dualread, issue_loadstore, issue_exc;
  logic          commit_valid, commit_kill;
  logic [XW-1:0] commit_id;
  logic          result_valid, result_ready;
  logic [XW-1:0] result_id;
  logic [31:0]   result_data;
  logic [4:0]    result_rd;
  logic          result_we, result_exc;
  logic [5:0]    result_exccode;

  xif_coproc_alu #(.DEPTH(DEPTH), .X_ID_WIDTH(XW)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_instr(issue_instr), .issue_id(issue_id),
    .issue_rs(issue_rs), .issue_rs_valid(issue_rs_valid),
    .issue_accept(issue_accept), .issue_writeback(issue_writeback),
    .issue_dualwrite(issue_dualwrite), .issue_dualread(issue_dualread),
    .issue_loadstore(issue_loadstore), .issue_exc(issue_exc),
    .commit_valid(commit_valid), .commit_id(commit_id), .commit_kill(commit_kill),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_id(result_id), .result_data(result_data), .result_rd(result_rd),
    .result_we(result_we), .result_exc(result_exc), .result_exccode(result_exccode)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        acc;
    logic        wb;
    logic [31:0] data;
  } vec_t;
  vec_t vt [8];

  // Reference model: one record per stored instruction, oldest first.
  // st: 0 waiting for commit, 1 committed, 2 killed.
  typedef struct {
    logic [XW-1:0] id;
    logic [4:0]    rd;
    logic [31:0]   data;
    logic          we;
    int            st;
  } mdl_t;
  mdl_t mq[$];
  logic [XW-1:0] next_id;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] act_bundle();
    return {14'b0, result_valid, result_id, result_rd, result_data,
            result_we, result_exc, result_exccode};
  endfunction

  task automatic expect_res(input string name, input logic v, input logic [XW-1:0] id,
                            input logic [4:0] rd, input logic [31:0] data, input logic we);
    if (v) chk(name, act_bundle(), {14'b0, 1'b1, id, rd, data, we, 1'b0, 6'b0});
    else   chk(name, {63'b0, result_valid}, 64'd0);
  endtask

  function automatic logic [31:0] mk_instr(input logic [6:0] f7, input logic [2:0] f3,
                                           input logic [4:0] rd, input logic [6:0] op);
    return {f7, 10'h155, f3, rd, op};
  endfunction

  // Behavioural decode/execute: returns acceptance, result via r.
  function automatic logic ref_op(input logic [31:0] instr, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] r);
    logic ok;
    ok = 1'b0;
    r  = '0;
    if (instr[6:0] == OPC && instr[31:25] == 7'd0) begin
      if (instr[14:12] == 3'd0) begin ok = 1'b1; r = a + b; end
      if (instr[14:12] == 3'd1) begin ok = 1'b1; r = a ^ b; end
      if (instr[14:12] == 3'd2 && SUB_EN) begin ok = 1'b1; r = a - b; end
    end
    return ok;
  endfunction

  // Driver tasks.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    issue_valid    = 1'b0;
    issue_instr    = '0;
    issue_id       = '0;
    issue_rs       = '0;
    issue_rs_valid = 2'b00;
    commit_valid   = 1'b0;
    commit_id      = '0;
    commit_kill    = 1'b0;
    result_ready   = 1'b0;
  endtask

  task automatic drive_issue(input logic [31:0] instr, input logic [XW-1:0] id,
                             input logic [31:0] a, input logic [31:0] b);
    issue_valid    = 1'b1;
    issue_instr    = instr;
    issue_id       = id;
    issue_rs       = {b, a};
    issue_rs_valid = 2'b11;
  endtask

  task automatic do_reset();
    for (int c = 0; c < 2; c++) begin
      step();
      rst = 1'b1;
      idle_inputs();
      drive_issue(mk_instr(7'd0, 3'd0, 5'd1, OPC), 4'd1, 32'd1, 32'd1);
      result_ready = 1'b1;
      at_neg();
      chk("rst_issue_ready", {63'b0, issue_ready}, 64'd0);
      chk("rst_result_bundle", act_bundle(), 64'd0);
    end
    step();
    rst = 1'b0;
    idle_inputs();
    at_neg();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    next_id = '0;

    vt[0] = '{7'h00, 3'b000, OPC,          5'd5,  32'hFFFFFFFF, 32'h2,        1'b1,   1'b1,   32'h00000001};
    vt[1] = '{7'h00, 3'b001, OPC,          5'd0,  32'hA5A5A5A5, 32'hFFFF0000, 1'b1,   1'b0,   32'h5A5AA5A5};
    vt[2] = '{7'h00, 3'b000, OPC,          5'd31, 32'h80000000, 32'h80000000, 1'b1,   1'b1,   32'h00000000};
    vt[3] = '{7'h00, 3'b011, OPC,          5'd3,  32'h1,        32'h2,        1'b0,   1'b0,   32'h0};
    vt[4] = '{7'h20, 3'b000, OPC,          5'd3,  32'h1,        32'h2,        1'b0,   1'b0,   32'h0};
    vt[5] = '{7'h00, 3'b000, 7'b0110011,   5'd3,  32'h1,        32'h2,        1'b0,   1'b0,   32'h0};
    vt[6] = '{7'h00, 3'b010, OPC,          5'd7,  32'd5,        32'd7,        SUB_EN, SUB_EN, 32'hFFFFFFFE};
    vt[7] = '{7'h00, 3'b001, OPC,          5'd12, 32'h12345678, 32'h12345678, 1'b1,   1'b1,   32'h0};

    do_reset();

    // Table: issue and commit in the same cycle, result the next cycle.
    for (int i = 0; i < 8; i++) begin
      step();
      idle_inputs();
      drive_issue(mk_instr(vt[i].f7, vt[i].f3, vt[i].rd, vt[i].op), XW'(i), vt[i].rs1, vt[i].rs2);
      commit_valid = 1'b1;
      commit_id    = XW'(i);
      at_neg();
      chk($sformatf("vec%0d_ready", i), {63'b0, issue_ready}, 64'd1);
      chk($sformatf("vec%0d_accept", i), {63'b0, issue_accept}, {63'b0, vt[i].acc});
      chk($sformatf("vec%0d_writeback", i), {63'b0, issue_writeback}, {63'b0, vt[i].wb});
      chk($sformatf("vec%0d_zero_flags", i),
          {60'b0, issue_dualwrite, issue_dualread, issue_loadstore, issue_exc}, 64'd0);
      step();
      idle_inputs();
      result_ready = 1'b1;
      at_neg();
      expect_res($sformatf("vec%0d_result", i), vt[i].acc, XW'(i), vt[i].rd, vt[i].data, vt[i].wb);
    end

    // ADD wrap-around, commit one cycle later, result held under back-pressure.
    do_reset();
    step(); idle_inputs();
    drive_issue(mk_instr(7'd0, 3'd0, 5'd5, OPC), 4'd3, 32'hFFFFFFFF, 32'd2);
    at_neg();
    step(); idle_inputs();
    commit_valid = 1'b1; commit_id = 4'd3;
    at_neg();
    expect_res("add_before_commit", 1'b0, '0, '0, '0, 1'b0);
    step(); idle_inputs();
    at_neg();
    expect_res("add_result", 1'b1, 4'd3, 5'd5, 32'h1, 1'b1);
    step(); idle_inputs();
    at_neg();
    expect_res("add_hold", 1'b1, 4'd3, 5'd5, 32'h1, 1'b1);
    step(); idle_inputs(); result_ready = 1'b1;
    at_neg();
    expect_res("add_hold2", 1'b1, 4'd3, 5'd5, 32'h1, 1'b1);
    step(); idle_inputs(); result_ready = 1'b1;
    at_neg();
    expect_res("add_popped", 1'b0, '0, '0, '0, 1'b0);

    // In-order return: commit 1, 2, then 0.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step(); idle_inputs(); result_ready = 1'b1;
      drive_issue(mk_instr(7'd0, 3'd0, 5'(k + 1), OPC), XW'(k), 32'(10 * k), 32'd1);
      at_neg();
    end
    for (int k = 0; k < 3; k++) begin
      step(); idle_inputs(); result_ready = 1'b1;
      commit_valid = 1'b1;
      commit_id    = XW'((k + 1) % 3);
      at_neg();
      expect_res($sformatf("order_wait%0d", k), 1'b0, '0, '0, '0, 1'b0);
    end
    for (int k = 0; k < 3; k++) begin
      step(); idle_inputs(); result_ready = 1'b1;
      at_neg();
      expect_res($sformatf("order_res%0d", k), 1'b1, XW'(k), 5'(k + 1), 32'(10 * k + 1), 1'b1);
    end
    step(); idle_inputs(); result_ready = 1'b1;
    at_neg();
    expect_res("order_empty", 1'b0, '0, '0, '0, 1'b0);

    // Kill drops silently, then fill to DEPTH and free one slot via result pop.
    do_reset();
    step(); idle_inputs(); result_ready = 1'b1;
    drive_issue(mk_instr(7'd0, 3'd0, 5'd1, OPC), 4'd7, 32'd1, 32'd1);
    at_neg();
    step(); idle_inputs(); result_ready = 1'b1;
    commit_valid = 1'b1; commit_id = 4'd7; commit_kill = 1'b1;
    at_neg();
    expect_res("kill_c1", 1'b0, '0, '0, '0, 1'b0);
    for (int c = 0; c < 2; c++) begin
      step(); idle_inputs(); result_ready = 1'b1;
      at_neg();
      expect_res($sformatf("kill_c%0d", c + 2), 1'b0, '0, '0, '0, 1'b0);
    end
    for (int k = 0; k < DEPTH; k++) begin
      step(); idle_inputs();
      drive_issue(mk_instr(7'd0, 3'd0, 5'd1, OPC), XW'(8 + k), 32'(k), 32'd100);
      at_neg();
      chk($sformatf("fill%0d_ready", k), {63'b0, issue_ready}, 64'd1);
    end
    step(); idle_inputs(); issue_rs_valid = 2'b11;
    at_neg();
    chk("full_ready", {63'b0, issue_ready}, 64'd0);
    step(); idle_inputs(); issue_rs_valid = 2'b11;
    commit_valid = 1'b1; commit_id = 4'd8; result_ready = 1'b1;
    at_neg();
    chk("full_commit_ready", {63'b0, issue_ready}, 64'd0);
    step(); idle_inputs(); issue_rs_valid = 2'b11; result_ready = 1'b1;
    at_neg();
    expect_res("full_result", 1'b1, 4'd8, 5'd1, 32'd100, 1'b1);
    chk("full_popcycle_ready", {63'b0, issue_ready}, 64'd0);
    step(); idle_inputs(); issue_rs_valid = 2'b11;
    at_neg();
    chk("after_pop_ready", {63'b0, issue_ready}, 64'd1);

    // Reset in the middle of a pending result discards it.
    do_reset();
    step(); idle_inputs();
    drive_issue(mk_instr(7'd0, 3'd0, 5'd4, OPC), 4'd2, 32'd10, 32'd20);
    commit_valid = 1'b1; commit_id = 4'd2;
    at_neg();
    step(); idle_inputs();
    at_neg();
    expect_res("mid_pending", 1'b1, 4'd2, 5'd4, 32'd30, 1'b1);
    step(); idle_inputs(); rst = 1'b1;
    at_neg();
    chk("mid_rst_bundle", act_bundle(), 64'd0);
    for (int c = 0; c < 2; c++) begin
      step(); idle_inputs(); rst = 1'b0; result_ready = 1'b1;
      at_neg();
      expect_res($sformatf("mid_after%0d", c), 1'b0, '0, '0, '0, 1'b0);
    end

    // Randomized traffic against the queue model.
    do_reset();
    mq.delete();
    next_id = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic        acc, exp_ready, exp_rv, do_push;
      logic [31:0] rdata, a, b;
      logic [6:0]  f7, op;
      logic [4:0]  rd;
      int          sel;
      mdl_t        e;

      step();
      idle_inputs();
      f7 = ($urandom_range(0, 9) == 0) ? 7'h20 : 7'h00;
      op = ($urandom_range(0, 9) == 0) ? 7'b0110011 : OPC;
      rd = 5'($urandom_range(0, 31));
      a  = $urandom;
      b  = $urandom;
      issue_valid    = ($urandom_range(0, 9) < 6);
      issue_instr    = mk_instr(f7, 3'($urandom_range(0, 3)), rd, op);
      issue_id       = next_id;
      issue_rs       = {b, a};
      issue_rs_valid = ($urandom_range(0, 9) < 9) ? 2'b11 : 2'($urandom_range(0, 2));
      commit_valid   = ($urandom_range(0, 1) == 1);
      sel = $urandom_range(0, 9);
      if (sel < 6 && mq.size() > 0) commit_id = mq[$urandom_range(0, mq.size() - 1)].id;
      else if (sel < 8)             commit_id = next_id;
      else                          commit_id = XW'($urandom_range(0, 15));
      commit_kill  = ($urandom_range(0, 9) < 3);
      result_ready = ($urandom_range(0, 9) < 7);

      acc       = ref_op(issue_instr, a, b, rdata);
      exp_ready = (mq.size() < DEPTH) && (issue_rs_valid == 2'b11);
      exp_rv    = (mq.size() > 0) && (mq[0].st == 1);

      at_neg();
      chk("rnd_ready", {63'b0, issue_ready}, {63'b0, exp_ready});
      chk("rnd_accept", {63'b0, issue_accept}, {63'b0, acc});
      chk("rnd_writeback", {63'b0, issue_writeback}, {63'b0, acc && rd != 5'd0});
      if (exp_rv) expect_res("rnd_result", 1'b1, mq[0].id, mq[0].rd, mq[0].data, mq[0].we);
      else        expect_res("rnd_result", 1'b0, '0, '0, '0, 1'b0);

      // Advance the model to the state after the coming clock edge.
      if (mq.size() > 0 && (mq[0].st == 2 || (mq[0].st == 1 && result_ready))) begin
        void'(mq.pop_front());
      end
      if (commit_valid) begin
        foreach (mq[j]) begin
          if (mq[j].st == 0 && mq[j].id == commit_id) mq[j].st = commit_kill ? 2 : 1;
        end
      end
      do_push = issue_valid && exp_ready && acc;
      if (do_push) begin
        e.id   = issue_id;
        e.rd   = rd;
        e.data = rdata;
        e.we   = (rd != 5'd0);
        e.st   = (commit_valid && commit_id == issue_id) ? (commit_kill ? 2 : 1) : 0;
        mq.push_back(e);
        next_id = next_id + 1'b1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
